// File: rtl/cu_pkg.sv
// Shared definitions for the mini-CPU hardwired control unit: opcodes, T-state
// encoding, strobe bit positions within the grouped control outputs.
package cu_pkg;

   typedef logic [4:0] opcode_t;

   localparam opcode_t OP_LD   = 5'b00000;
   localparam opcode_t OP_ST   = 5'b00010;
   localparam opcode_t OP_ADD  = 5'b00011;
   localparam opcode_t OP_SUB  = 5'b00100;
   localparam opcode_t OP_AND  = 5'b00101;
   localparam opcode_t OP_OR   = 5'b00110;
   localparam opcode_t OP_ADDI = 5'b01100;
   localparam opcode_t OP_ANDI = 5'b01101;
   localparam opcode_t OP_ORI  = 5'b01110;
   localparam opcode_t OP_BR   = 5'b10010;
   localparam opcode_t OP_JR   = 5'b10011;
   localparam opcode_t OP_IN   = 5'b10110;
   localparam opcode_t OP_OUT  = 5'b10111;
   localparam opcode_t OP_NOP  = 5'b11010;
   localparam opcode_t OP_HALT = 5'b11011;

   localparam opcode_t ALU_ADD = 5'b00011;

   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_T7   = 4'd8,
      ST_HALT = 4'd9
   } state_e;

   // bus_sel bit positions
   localparam logic [3:0] BUS_PC  = 4'd0;
   localparam logic [3:0] BUS_ZH  = 4'd1;
   localparam logic [3:0] BUS_ZL  = 4'd2;
   localparam logic [3:0] BUS_MDR = 4'd3;
   localparam logic [3:0] BUS_HI  = 4'd4;
   localparam logic [3:0] BUS_LO  = 4'd5;
   localparam logic [3:0] BUS_IN  = 4'd6;
   localparam logic [3:0] BUS_C   = 4'd7;
   localparam logic [3:0] BUS_R   = 4'd8;
   localparam logic [3:0] BUS_RAM = 4'd9;

   // reg_ld bit positions
   localparam logic [3:0] LD_MAR = 4'd0;
   localparam logic [3:0] LD_PC  = 4'd1;
   localparam logic [3:0] LD_MDR = 4'd2;
   localparam logic [3:0] LD_IR  = 4'd3;
   localparam logic [3:0] LD_Y   = 4'd4;
   localparam logic [3:0] LD_HI  = 4'd5;
   localparam logic [3:0] LD_LO  = 4'd6;
   localparam logic [3:0] LD_ZH  = 4'd7;
   localparam logic [3:0] LD_ZL  = 4'd8;
   localparam logic [3:0] LD_OUT = 4'd9;

   // gsel bit positions
   localparam logic [1:0] G_RA = 2'd0;
   localparam logic [1:0] G_RB = 2'd1;
   localparam logic [1:0] G_RC = 2'd2;
   localparam logic [1:0] G_BA = 2'd3;

   // Index of the final T-state of an opcode's sequence; 2 means fetch only.
   function automatic logic [2:0] last_step(input opcode_t op);
      logic [2:0] r;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_ADDI, OP_ANDI, OP_ORI:   r = 3'd5;
         OP_LD, OP_ST:               r = 3'd7;
         OP_BR:                      r = 3'd6;
         OP_JR, OP_IN, OP_OUT:       r = 3'd3;
         OP_NOP:                     r = 3'd2;
         default:                    r = 3'd2;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational strobe decoder: (T-state, latched opcode, branch flag) to every
// datapath control output. Zero in RST and HALT.
module cu_decode
   import cu_pkg::*;
(
   input  state_e      state_i,
   input  opcode_t     opcode_i,
   input  logic        bflag_i,
   output logic [9:0]  bus_sel_o,
   output logic [9:0]  reg_ld_o,
   output logic [3:0]  gsel_o,
   output logic        rin_o,
   output logic        inc_pc_o,
   output logic        read_o,
   output logic        write_o,
   output logic [4:0]  alu_op_o,
   output logic        run_o
);

   logic is_alu;
   logic is_imm;
   logic is_mem;

   assign is_alu = (opcode_i == OP_ADD) || (opcode_i == OP_SUB) ||
                   (opcode_i == OP_AND) || (opcode_i == OP_OR);
   assign is_imm = (opcode_i == OP_ADDI) || (opcode_i == OP_ANDI) ||
                   (opcode_i == OP_ORI);
   assign is_mem = (opcode_i == OP_LD) || (opcode_i == OP_ST);

   always_comb begin
      bus_sel_o = '0;
      reg_ld_o  = '0;
      gsel_o    = '0;
      rin_o     = 1'b0;
      inc_pc_o  = 1'b0;
      read_o    = 1'b0;
      write_o   = 1'b0;
      alu_op_o  = '0;
      run_o     = 1'b1;
      case (state_i)
         ST_T0: begin
            bus_sel_o[BUS_PC] = 1'b1;
            reg_ld_o[LD_MAR]  = 1'b1;
            reg_ld_o[LD_ZH]   = 1'b1;
            reg_ld_o[LD_ZL]   = 1'b1;
            inc_pc_o          = 1'b1;
            alu_op_o          = ALU_ADD;
         end
         ST_T1: begin
            bus_sel_o[BUS_ZL] = 1'b1;
            reg_ld_o[LD_PC]   = 1'b1;
            reg_ld_o[LD_MDR]  = 1'b1;
            read_o            = 1'b1;
         end
         ST_T2: begin
            bus_sel_o[BUS_MDR] = 1'b1;
            reg_ld_o[LD_IR]    = 1'b1;
         end
         ST_T3: begin
            if (is_alu || is_imm) begin
               gsel_o[G_RB]     = 1'b1;
               bus_sel_o[BUS_R] = 1'b1;
               reg_ld_o[LD_Y]   = 1'b1;
            end else if (is_mem) begin
               gsel_o[G_RB]   = 1'b1;
               gsel_o[G_BA]   = 1'b1;
               reg_ld_o[LD_Y] = 1'b1;
            end else if (opcode_i == OP_BR) begin
               gsel_o[G_RA]     = 1'b1;
               bus_sel_o[BUS_R] = 1'b1;
            end else if (opcode_i == OP_JR) begin
               gsel_o[G_RA]     = 1'b1;
               bus_sel_o[BUS_R] = 1'b1;
               reg_ld_o[LD_PC]  = 1'b1;
            end else if (opcode_i == OP_IN) begin
               bus_sel_o[BUS_IN] = 1'b1;
               gsel_o[G_RA]      = 1'b1;
               rin_o             = 1'b1;
            end else if (opcode_i == OP_OUT) begin
               gsel_o[G_RA]     = 1'b1;
               bus_sel_o[BUS_R] = 1'b1;
               reg_ld_o[LD_OUT] = 1'b1;
            end
         end
         ST_T4: begin
            if (is_alu) begin
               gsel_o[G_RC]     = 1'b1;
               bus_sel_o[BUS_R] = 1'b1;
               reg_ld_o[LD_ZH]  = 1'b1;
               reg_ld_o[LD_ZL]  = 1'b1;
               alu_op_o         = opcode_i;
            end else if (is_imm) begin
               bus_sel_o[BUS_C] = 1'b1;
               reg_ld_o[LD_ZH]  = 1'b1;
               reg_ld_o[LD_ZL]  = 1'b1;
               alu_op_o         = opcode_i;
            end else if (is_mem) begin
               bus_sel_o[BUS_C] = 1'b1;
               reg_ld_o[LD_ZH]  = 1'b1;
               reg_ld_o[LD_ZL]  = 1'b1;
               alu_op_o         = ALU_ADD;
            end else if (opcode_i == OP_BR) begin
               bus_sel_o[BUS_PC] = 1'b1;
               reg_ld_o[LD_Y]    = 1'b1;
            end
         end
         ST_T5: begin
            if (is_alu || is_imm) begin
               bus_sel_o[BUS_ZL] = 1'b1;
               gsel_o[G_RA]      = 1'b1;
               rin_o             = 1'b1;
            end else if (is_mem) begin
               bus_sel_o[BUS_ZL] = 1'b1;
               reg_ld_o[LD_MAR]  = 1'b1;
            end else if (opcode_i == OP_BR) begin
               bus_sel_o[BUS_C] = 1'b1;
               reg_ld_o[LD_ZH]  = 1'b1;
               reg_ld_o[LD_ZL]  = 1'b1;
               alu_op_o         = ALU_ADD;
            end
         end
         ST_T6: begin
            if (opcode_i == OP_LD) begin
               read_o           = 1'b1;
               reg_ld_o[LD_MDR] = 1'b1;
            end else if (opcode_i == OP_ST) begin
               gsel_o[G_RA]     = 1'b1;
               bus_sel_o[BUS_R] = 1'b1;
               reg_ld_o[LD_MDR] = 1'b1;
            end else if (opcode_i == OP_BR) begin
               bus_sel_o[BUS_ZL] = 1'b1;
               reg_ld_o[LD_PC]   = bflag_i;
            end
         end
         ST_T7: begin
            if (opcode_i == OP_LD) begin
               bus_sel_o[BUS_MDR] = 1'b1;
               gsel_o[G_RA]       = 1'b1;
               rin_o              = 1'b1;
            end else if (opcode_i == OP_ST) begin
               write_o = 1'b1;
            end
         end
         default: run_o = 1'b0;
      endcase
      // HI/LO, Zhigh and RAM paths are never sourced by this instruction set.
      bus_sel_o[BUS_ZH]  = 1'b0;
      bus_sel_o[BUS_HI]  = 1'b0;
      bus_sel_o[BUS_LO]  = 1'b0;
      bus_sel_o[BUS_RAM] = 1'b0;
      reg_ld_o[LD_HI]    = 1'b0;
      reg_ld_o[LD_LO]    = 1'b0;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state sequencer for the mini CPU. Optional CU_MEM_WAIT_EN adds a
// mem_ready input that stretches every Read/Write step until memory completes.
module control_sequencer
   import cu_pkg::*;
#(
   parameter int OPW = 5
) (
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] irOut,
   input  logic        branchCompare,
`ifdef CU_MEM_WAIT_EN
   input  logic        mem_ready,
`endif
   output logic [9:0]  bus_sel,
   output logic [9:0]  reg_ld,
   output logic [3:0]  gsel,
   output logic        Rin,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic [4:0]  alu_op,
   output logic        Run
);

   state_e           state_q, state_d;
   logic [OPW-1:0]   opcode_q, opcode_d;
   logic             bflag_q, bflag_d;
   opcode_t          ir_op;
   opcode_t          op_q;
   logic [2:0]       step;
   logic [2:0]       last;
   logic             mem_hold;
   logic             unused_ir;

   assign ir_op     = opcode_t'(irOut[31 -: OPW]);
   assign op_q      = opcode_t'(opcode_q);
   assign unused_ir = ^irOut[31-OPW:0];

`ifdef CU_MEM_WAIT_EN
   assign mem_hold = (Read | Write) & ~mem_ready;
`else
   assign mem_hold = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      bflag_d  = bflag_q;
      step     = 3'(4'(state_q) - 4'(ST_T0));
      last     = last_step(op_q);
      case (state_q)
         ST_RST: state_d = ST_T0;
         ST_T0:  state_d = ST_T1;
         ST_T1:  state_d = ST_T2;
         ST_T2: begin
            // IR is loaded from the bus on this edge; capture its opcode alongside.
            opcode_d = irOut[31 -: OPW];
            if (ir_op == OP_HALT)
               state_d = ST_HALT;
            else if (last_step(ir_op) == 3'd2)
               state_d = ST_T0;
            else
               state_d = ST_T3;
         end
         ST_T3, ST_T4, ST_T5, ST_T6: begin
            if ((state_q == ST_T3) && (op_q == OP_BR))
               bflag_d = branchCompare;
            state_d = (step >= last) ? ST_T0 : state_e'(4'(state_q) + 4'd1);
         end
         ST_T7:   state_d = ST_T0;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RST;
      endcase
      if (mem_hold)
         state_d = state_q;
   end

   always_ff @(posedge Clock) begin
      if (clear) begin
         state_q  <= ST_RST;
         opcode_q <= '0;
         bflag_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         bflag_q  <= bflag_d;
      end
   end

   cu_decode u_decode (
      .state_i   (state_q),
      .opcode_i  (op_q),
      .bflag_i   (bflag_q),
      .bus_sel_o (bus_sel),
      .reg_ld_o  (reg_ld),
      .gsel_o    (gsel),
      .rin_o     (Rin),
      .inc_pc_o  (IncPC),
      .read_o    (Read),
      .write_o   (Write),
      .alu_op_o  (alu_op),
      .run_o     (Run)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected strobe sequences built
// from the instruction table, compared cycle by cycle against the DUT.
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        clear = 1'b1;
   logic [31:0] irOut = 32'h0;
   logic        branchCompare = 1'b0;
`ifdef CU_MEM_WAIT_EN
   logic        mem_ready = 1'b1;
`endif
   logic [9:0]  bus_sel;
   logic [9:0]  reg_ld;
   logic [3:0]  gsel;
   logic        Rin, IncPC, Read, Write, Run;
   logic [4:0]  alu_op;

   control_sequencer #(.OPW(5)) dut (
      .Clock         (Clock),
      .clear         (clear),
      .irOut         (irOut),
      .branchCompare (branchCompare),
`ifdef CU_MEM_WAIT_EN
      .mem_ready     (mem_ready),
`endif
      .bus_sel       (bus_sel),
      .reg_ld        (reg_ld),
      .gsel          (gsel),
      .Rin           (Rin),
      .IncPC         (IncPC),
      .Read          (Read),
      .Write         (Write),
      .alu_op        (alu_op),
      .Run           (Run)
   );

   always #5 Clock = ~Clock;

   // Control word: {Run, bus_sel, reg_ld, gsel, Rin, IncPC, Read, Write, alu_op}
   typedef logic [33:0] cw_t;

   localparam logic [9:0] B_PC = 10'h001, B_ZL = 10'h004, B_MDR = 10'h008,
                          B_IN = 10'h040, B_C  = 10'h080, B_R   = 10'h100;
   localparam logic [9:0] L_MAR = 10'h001, L_PC = 10'h002, L_MDR = 10'h004,
                          L_IR  = 10'h008, L_Y  = 10'h010, L_ZH  = 10'h080,
                          L_ZL  = 10'h100, L_OUT = 10'h200;
   localparam logic [3:0] G_A = 4'h1, G_B = 4'h2, G_C = 4'h4, G_BA = 4'h8, G_0 = 4'h0;
   localparam logic [3:0] F_RIN = 4'b1000, F_INC = 4'b0100, F_RD = 4'b0010,
                          F_WR = 4'b0001, F_0 = 4'b0000;
   localparam logic [9:0] NONE = 10'h000;
   localparam logic [4:0] A_ADD = 5'b00011, A_0 = 5'b00000;

   int total = 0;
   int bad   = 0;
   cw_t exp_q[$];

   function automatic cw_t mk(input logic [9:0] b, input logic [9:0] l,
                              input logic [3:0] g, input logic [3:0] f,
                              input logic [4:0] alu);
      return {1'b1, b, l, g, f, alu};
   endfunction

   function automatic cw_t observed();
      return {Run, bus_sel, reg_ld, gsel, Rin, IncPC, Read, Write, alu_op};
   endfunction

   task automatic check(input string tag, input cw_t expv);
      cw_t obs;
      obs = observed();
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step_clk();
      @(posedge Clock);
      #1;
   endtask

   // Expected per-cycle control words from T0 to the last step of one instruction.
   task automatic build(input logic [31:0] ir, input logic bc);
      logic [4:0] op;
      op = ir[31:27];
      exp_q.delete();
      exp_q.push_back(mk(B_PC,  L_MAR | L_ZH | L_ZL, G_0, F_INC, A_ADD));
      exp_q.push_back(mk(B_ZL,  L_PC | L_MDR,        G_0, F_RD,  A_0));
      exp_q.push_back(mk(B_MDR, L_IR,                G_0, F_0,   A_0));
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6: begin
            exp_q.push_back(mk(B_R,  L_Y,         G_B, F_0,   A_0));
            exp_q.push_back(mk(B_R,  L_ZH | L_ZL, G_C, F_0,   op));
            exp_q.push_back(mk(B_ZL, NONE,        G_A, F_RIN, A_0));
         end
         5'd12, 5'd13, 5'd14: begin
            exp_q.push_back(mk(B_R,  L_Y,         G_B, F_0,   A_0));
            exp_q.push_back(mk(B_C,  L_ZH | L_ZL, G_0, F_0,   op));
            exp_q.push_back(mk(B_ZL, NONE,        G_A, F_RIN, A_0));
         end
         5'd0, 5'd2: begin
            exp_q.push_back(mk(NONE, L_Y,         G_B | G_BA, F_0, A_0));
            exp_q.push_back(mk(B_C,  L_ZH | L_ZL, G_0,        F_0, A_ADD));
            exp_q.push_back(mk(B_ZL, L_MAR,       G_0,        F_0, A_0));
            if (op == 5'd0) begin
               exp_q.push_back(mk(NONE,  L_MDR, G_0, F_RD,  A_0));
               exp_q.push_back(mk(B_MDR, NONE,  G_A, F_RIN, A_0));
            end else begin
               exp_q.push_back(mk(B_R,  L_MDR, G_A, F_0,  A_0));
               exp_q.push_back(mk(NONE, NONE,  G_0, F_WR, A_0));
            end
         end
         5'd18: begin
            exp_q.push_back(mk(B_R,  NONE,              G_A, F_0, A_0));
            exp_q.push_back(mk(B_PC, L_Y,               G_0, F_0, A_0));
            exp_q.push_back(mk(B_C,  L_ZH | L_ZL,       G_0, F_0, A_ADD));
            exp_q.push_back(mk(B_ZL, bc ? L_PC : NONE,  G_0, F_0, A_0));
         end
         5'd19: exp_q.push_back(mk(B_R,  L_PC,  G_A, F_0,   A_0));
         5'd22: exp_q.push_back(mk(B_IN, NONE,  G_A, F_RIN, A_0));
         5'd23: exp_q.push_back(mk(B_R,  L_OUT, G_A, F_0,   A_0));
         default: ;
      endcase
   endtask

   // Entered at T0 (1 time unit after the edge); leaves at the next instruction's T0.
   task automatic run_instr(input string tag, input logic [31:0] ir, input logic bc,
                            input int abort_step, input int ld_wait);
      int cycles;
      cw_t w;
      cycles = 0;
      irOut = ir;
      build(ir, bc);
      for (int s = 0; s < exp_q.size(); s++) begin
         int k;
         w = exp_q[s];
         k = 0;
         branchCompare = (s == 3) ? bc : ~bc;
`ifdef CU_MEM_WAIT_EN
         if (w[6] | w[5])
            k = (ld_wait >= 0 && s == 6) ? ld_wait : int'($urandom_range(0, 2));
`endif
         for (int j = 0; j <= k; j++) begin
`ifdef CU_MEM_WAIT_EN
            mem_ready = (j == k);
`endif
            check(tag, w);
            cycles++;
            if (s == abort_step) begin
               $display("instr %s ir=%h bc=%0b aborted at step %0d", tag, ir, bc, s);
               return;
            end
            step_clk();
         end
      end
      $display("instr %s ir=%h bc=%0b wait=%0d cycles=%0d", tag, ir, bc, ld_wait, cycles);
   endtask

   // Holds clear for 'hold' edges; afterwards the DUT sits at T0.
   task automatic do_reset(input int hold);
      clear = 1'b1;
`ifdef CU_MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      for (int i = 0; i < hold; i++) begin
         step_clk();
         if (i == hold - 1) clear = 1'b0;
         check("reset_rst", '0);
      end
      step_clk();
      $display("reset hold=%0d", hold);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check("reset_initial", '0);
      do_reset(3);

      run_instr("addi", 32'h61A0_000F, 1'b0, -1, -1);
      run_instr("addi_again", 32'h61A0_000F, 1'b1, -1, -1);
      run_instr("add", 32'h1891_8000, 1'b0, -1, -1);
      run_instr("br_taken", 32'h92C0_0000, 1'b1, -1, -1);
      run_instr("br_not_taken", 32'h92C0_0000, 1'b0, -1, -1);
      run_instr("ld", 32'h0090_0005, 1'b0, -1, 3);
      run_instr("st", 32'h1090_0005, 1'b0, -1, -1);
      run_instr("nop", 32'hD000_0000, 1'b0, -1, -1);
      run_instr("jr", 32'h9880_0000, 1'b1, -1, -1);

      run_instr("st_abort", 32'h1090_0005, 1'b0, 6, -1);
      do_reset(1);

      for (int n = 0; n < 60; n++) begin
         logic [4:0] op;
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27) op = 5'd26;
         run_instr("rand", {op, 27'($urandom)}, 1'($urandom_range(0, 1)), -1, -1);
      end

      run_instr("halt", 32'hD800_0000, 1'b0, -1, -1);
      for (int i = 0; i < 20; i++) begin
         irOut = $urandom;
         branchCompare = 1'($urandom_range(0, 1));
         check("halt_idle", '0);
         step_clk();
      end
      do_reset(2);
      run_instr("after_halt_or", 32'h3000_0000, 1'b0, -1, -1);
      run_instr("out", 32'hB880_0000, 1'b0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
